// File: rtl/vid_mem_if.sv
// Synchronous read port between the scan-out stage and the video memory.
// rd_data is expected one clock after the cycle in which rd_en is high.
interface vid_mem_if;
  logic        rd_en;
  logic [14:0] rd_addr;
  logic [31:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/vid_scan.sv
// vid_scan: XGA raster timing plus 1-bit pixel serializer for the B/W video path.
// Counters (hcount, vcount) drive registered hsync/vsync/blank/pix with latency 1.
// Frame-buffer words are fetched two pixel clocks ahead of their first pixel.
// Optional build macro VID_INVERT_EN adds a frame-synchronous 'invert' input.
module vid_scan #(
  parameter int H_VIS  = 1024,
  parameter int H_FP   = 24,
  parameter int H_SYNC = 136,
  parameter int H_BP   = 160,
  parameter int V_VIS  = 768,
  parameter int V_FP   = 3,
  parameter int V_SYNC = 6,
  parameter int V_BP   = 29
) (
  input  logic      clk,
  input  logic      rst,
  vid_mem_if.master mem,
`ifdef VID_INVERT_EN
  input  logic      invert,
`endif
  output logic      hsync,
  output logic      vsync,
  output logic      blank,
  output logic      pix
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_PRE  = 11'(H_TOTAL - 2);
  localparam logic [10:0] H_VISC = 11'(H_VIS);
  localparam logic [10:0] H_LWRD = 11'(H_VIS - 2);
  localparam logic [10:0] HS_BEG = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VISC = 10'(V_VIS);
  localparam logic [9:0]  VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_VIS + V_FP + V_SYNC);

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        fresh_q, fresh_d;     // still in line 0 of the first frame after reset
  logic        rd_en_q, rd_en_d;
  logic [14:0] rd_addr_q, rd_addr_d;
  logic        pend_q, pend_d;       // rd_data is valid this cycle
  logic [31:0] hold_q, hold_d;
  logic [31:0] shift_q, shift_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d, pix_q, pix_d;
  logic        inv_q, inv_d;
  logic        h_wrap, vis, raw;
  logic [9:0]  fetch_line;
  logic [4:0]  fetch_word;

  assign mem.rd_en   = rd_en_q;
  assign mem.rd_addr = rd_addr_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign blank = blank_q;
  assign pix   = pix_q;

  // Raster counters; fresh clears at the first line wrap after reset.
  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (h_wrap) vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
    fresh_d  = fresh_q & ~h_wrap;
  end

  // Fetch decode on the next counter value so rd_en is high while hcount = 32w-2.
  // Line 0 of the first frame is skipped: its word 0 slot already went by.
  always_comb begin
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    fetch_line = vcount_d;
    fetch_word = 5'(hcount_d[9:5] + 5'd1);
    if (hcount_d == H_PRE) begin
      fetch_line = (vcount_d == V_LAST) ? 10'd0 : vcount_d + 10'd1;
      fetch_word = 5'd0;
      rd_en_d    = (fetch_line < V_VISC);
    end else if (hcount_d[4:0] == 5'd30 && hcount_d < H_LWRD) begin
      rd_en_d = (vcount_d < V_VISC) && !(fresh_q && vcount_d == 10'd0);
    end
    if (rd_en_d) rd_addr_d = {fetch_line, fetch_word};
  end

  // Capture read data, serialize LSB first, and form the registered raster outputs.
  always_comb begin
    pend_d  = rd_en_q;
    hold_d  = pend_q ? mem.rd_data : hold_q;
    vis     = (hcount_q < H_VISC) && (vcount_q < V_VISC);
    raw     = shift_q[0];
    shift_d = shift_q;
    if (vis && hcount_q[4:0] == 5'd0) begin
      raw     = hold_q[0];
      shift_d = hold_q >> 1;
    end else if (vis) begin
      shift_d = shift_q >> 1;
    end
`ifdef VID_INVERT_EN
    inv_d = (hcount_d == 11'd0 && vcount_d == 10'd0) ? invert : inv_q;
`else
    inv_d = 1'b0;
`endif
    hsync_d = !(hcount_q >= HS_BEG && hcount_q < HS_END);
    vsync_d = !(vcount_q >= VS_BEG && vcount_q < VS_END);
    blank_d = !vis;
    pix_d   = vis & (raw ^ inv_q);
  end

  // State registers, asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_q  <= '0;
      vcount_q  <= '0;
      fresh_q   <= 1'b1;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      pend_q    <= 1'b0;
      hold_q    <= '0;
      shift_q   <= '0;
      inv_q     <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      blank_q   <= 1'b1;
      pix_q     <= 1'b0;
    end else begin
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      fresh_q   <= fresh_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      pend_q    <= pend_d;
      hold_q    <= hold_d;
      shift_q   <= shift_d;
      inv_q     <= inv_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      blank_q   <= blank_d;
      pix_q     <= pix_d;
    end
  end
endmodule
